kernel_a_seq_ctrl: RTL and testbench
====================================

KERNEL_A_SEQ_CTRL -- requirements
Module: kernel_a_seq_ctrl

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 The block SHALL provide parameter CNTW, default 16, the width of the item counters and num_items.
REQ-003 The block SHALL provide parameter TIMEOUT, default 1024, the watchdog idle-cycle limit (used only with KERNEL_A_SEQ_TIMEOUT_EN).
REQ-004 The block SHALL provide port clk  in  1  clock, all logic on rising edge.
REQ-005 The block SHALL provide port rst  in  1  synchronous reset, active-low.
REQ-006 The block SHALL provide port start  in  1  job start request, sampled in IDLE only.
REQ-007 The block SHALL provide port num_items  in  CNTW  job length in beats, latched on accepted start.
REQ-008 The block SHALL provide ports src_valid in 1 / src_ready out 1  upstream handshake.
REQ-009 The block SHALL provide ports k_ivalid out 1 / k_iready in 1  kernel_A input handshake.
REQ-010 The block SHALL provide ports k_ovalid in 1 / k_oready out 1  kernel_A output handshake.
REQ-011 The block SHALL provide ports snk_valid out 1 / snk_ready in 1  downstream handshake.
REQ-012 The block SHALL provide ports busy out 1, done out 1, err out 1, in_cnt out CNTW, out_cnt out CNTW.

Function
REQ-013 The block SHALL implement states IDLE, RUN, DRAIN, DONE, plus ERR when KERNEL_A_SEQ_TIMEOUT_EN is defined.
REQ-014 In IDLE with start=1, the block SHALL latch num_items as N, clear both counters, and go to RUN, or to DONE if N=0.
REQ-015 start outside IDLE SHALL be ignored.
REQ-016 Input gating, combinational: the block SHALL drive k_ivalid=src_valid&gate_in and src_ready=k_iready&gate_in, where gate_in=(state==RUN)&(in_cnt<N).
REQ-017 Output gating, combinational: the block SHALL drive snk_valid=k_ovalid&gate_out and k_oready=snk_ready&gate_out, where gate_out=(state==RUN|DRAIN)&(out_cnt<N).
REQ-018 in_cnt SHALL increment by 1 on each cycle with k_ivalid&k_iready.
REQ-019 out_cnt SHALL increment by 1 on each cycle with k_ovalid&k_oready.
REQ-020 Neither counter SHALL wrap or exceed N.
REQ-021 When the last input beat (in_cnt becomes N) is accepted, RUN SHALL go to DRAIN the next cycle.
REQ-022 If out_cnt reaches N in the same cycle, RUN SHALL go directly to DONE instead.
REQ-023 DRAIN SHALL go to DONE on the cycle after out_cnt becomes N.
REQ-024 DONE SHALL last exactly one cycle with done=1 and then return to IDLE.
REQ-025 A start asserted during DONE SHALL be ignored.
REQ-026 busy SHALL be 1 in RUN and DRAIN, and 0 otherwise.
REQ-027 Counters SHALL hold their final values in DONE/IDLE until the next accepted start.
REQ-028 In IDLE, DONE and ERR, src_ready, k_ivalid, k_oready and snk_valid SHALL all be 0, so stray kernel outputs are back-pressured.

Reset
REQ-029 On rst=0 at a clock edge, the block SHALL enter IDLE and set N=0, in_cnt=0, out_cnt=0, busy=0, done=0 and err=0, and clear the watchdog.
REQ-030 Reset mid-job SHALL abort the job with no done pulse.
REQ-031 While rst=0, all handshake outputs SHALL be 0.

Configuration
REQ-032 With macro KERNEL_A_SEQ_TIMEOUT_EN defined, the block SHALL run a watchdog counter in RUN/DRAIN that clears on any accepted input or output beat, and otherwise increments.
REQ-033 With KERNEL_A_SEQ_TIMEOUT_EN defined, when the watchdog count reaches TIMEOUT the block SHALL enter ERR.
REQ-034 In ERR, the block SHALL set err=1 and busy=0, give no done pulse, and leave ERR only on reset.
REQ-035 With KERNEL_A_SEQ_TIMEOUT_EN undefined, the block SHALL have no watchdog and no ERR state, err SHALL be tied to 0, and RUN/DRAIN SHALL wait indefinitely.

Verification
REQ-036 Basic job: N=8, src_valid=1, k_iready=1, kernel latency 2, snk_ready=1 -> exactly 8 beats in and 8 out, in_cnt=out_cnt=8, one done pulse, busy deasserted the same cycle done rises.
REQ-037 Zero length: start with N=0 -> DONE the next cycle, done=1 for 1 cycle, src_ready never 1.
REQ-038 Back-pressure: N=4, snk_ready toggling 1/0 each cycle, k_iready low for 3 cycles -> no beat lost or duplicated, out_cnt=4, src_ready=0 after the 4th input.
REQ-039 Overrun guard: N=3, src_valid held high -> k_ivalid drops after 3 accepted beats; an extra k_ovalid in IDLE sees k_oready=0.
REQ-040 Reset mid-job: rst=0 at in_cnt=2 of N=5 -> next cycle IDLE, counters 0, no done; a following start N=2 completes normally.
REQ-041 Timeout (macro on, TIMEOUT=16): N=4, kernel never asserts k_ovalid -> err=1 sixteen cycles after the last input beat, done never pulses, and err stays 1 until reset.

Source files
------------

// File: rtl/kernel_a_seq_ctrl.sv
// Job sequencer wrapped around kernel_A: admits exactly N input beats, waits for N output beats, then pulses done.
// Optional idle watchdog with a sticky ERR state is built when KERNEL_A_SEQ_TIMEOUT_EN is defined.
module kernel_a_seq_ctrl #(
    parameter int unsigned CNTW    = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [CNTW-1:0] num_items,
    input  logic            src_valid,
    output logic            src_ready,
    output logic            k_ivalid,
    input  logic            k_iready,
    input  logic            k_ovalid,
    output logic            k_oready,
    output logic            snk_valid,
    input  logic            snk_ready,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [CNTW-1:0] in_cnt,
    output logic [CNTW-1:0] out_cnt
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        DONE  = 3'd3
`ifdef KERNEL_A_SEQ_TIMEOUT_EN
        , ERR = 3'd4
`endif
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CNTW-1:0] n_items;
    logic            gate_in;
    logic            gate_out;
    logic            in_fire;
    logic            out_fire;
    logic [CNTW-1:0] in_cnt_nxt;
    logic [CNTW-1:0] out_cnt_nxt;
    logic            in_last;
    logic            out_full;
    logic            accept;

    // State register with state-decoded status flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == RUN) || (state_nxt == DRAIN);
            done  <= (state_nxt == DONE);
        end
    end

    // Handshake gating; reset forces every handshake output low combinationally
    always_comb begin
        gate_in     = rst && (state == RUN) && (in_cnt < n_items);
        gate_out    = rst && ((state == RUN) || (state == DRAIN)) && (out_cnt < n_items);
        k_ivalid    = src_valid && gate_in;
        src_ready   = k_iready && gate_in;
        snk_valid   = k_ovalid && gate_out;
        k_oready    = snk_ready && gate_out;
        in_fire     = src_valid && k_iready && gate_in;
        out_fire    = k_ovalid && snk_ready && gate_out;
        in_cnt_nxt  = in_fire ? in_cnt + CNTW'(1) : in_cnt;
        out_cnt_nxt = out_fire ? out_cnt + CNTW'(1) : out_cnt;
        in_last     = in_fire && (in_cnt_nxt == n_items);
        out_full    = (out_cnt_nxt == n_items);
        accept      = (state == IDLE) && start;
    end

`ifdef KERNEL_A_SEQ_TIMEOUT_EN
    localparam int unsigned WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wd_cnt;
    logic [WDW-1:0] wd_nxt;
    logic           wd_expire;

    always_comb begin
        wd_nxt    = (in_fire || out_fire) ? '0 : wd_cnt + WDW'(1);
        wd_expire = (wd_nxt == WDW'(TIMEOUT));
    end

    // Watchdog only runs while a job is active; any beat restarts the idle count
    always_ff @(posedge clk) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if ((state == RUN) || (state == DRAIN)) begin
            wd_cnt <= wd_nxt;
        end else begin
            wd_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            err <= 1'b0;
        end else begin
            err <= (state_nxt == ERR);
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = 1'(TIMEOUT & 32'd1);
    assign err            = 1'b0;
`endif

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (num_items == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (in_last) begin
                    state_nxt = out_full ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (out_full) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
`ifdef KERNEL_A_SEQ_TIMEOUT_EN
            ERR: begin
                state_nxt = ERR;
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
`ifdef KERNEL_A_SEQ_TIMEOUT_EN
        if (((state == RUN) || (state == DRAIN)) && wd_expire) begin
            state_nxt = ERR;
        end
`endif
    end

    // Job length and beat counters; counters hold until the next accepted start
    always_ff @(posedge clk) begin
        if (!rst) begin
            n_items <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else if (accept) begin
            n_items <= num_items;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            in_cnt  <= in_cnt_nxt;
            out_cnt <= out_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_kernel_a_seq_ctrl.sv
// Directed self-checking bench for kernel_a_seq_ctrl with a latency-2 FIFO kernel model.
// Exercises the watchdog path instead of the wait-forever path when KERNEL_A_SEQ_TIMEOUT_EN is defined.
module tb_kernel_a_seq_ctrl;

`ifdef KERNEL_A_SEQ_TIMEOUT_EN
    localparam int unsigned TB_TIMEOUT = 16;
`else
    localparam int unsigned TB_TIMEOUT = 1024;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_items;
    logic        src_valid;
    logic        src_ready;
    logic        k_ivalid;
    logic        k_iready;
    logic        k_ovalid;
    logic        k_oready;
    logic        snk_valid;
    logic        snk_ready;
    logic        busy;
    logic        done;
    logic        err;
    logic [15:0] in_cnt;
    logic [15:0] out_cnt;

    logic        kov_model = 1'b0;
    logic        stray_ov  = 1'b0;
    logic        kern_en   = 1'b0;

    int checks   = 0;
    int failures = 0;

    int cyc       = 0;
    int src_id    = 0;
    int exp_id    = 0;
    int in_beats  = 0;
    int out_beats = 0;
    int done_cnt  = 0;
    int sr_hi     = 0;
    int seq_err   = 0;
    int kq[$];
    int kt[$];

    int b_in, b_out, b_done, b_sr, b_seq;

    kernel_a_seq_ctrl #(.CNTW(16), .TIMEOUT(TB_TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_items (num_items),
        .src_valid (src_valid),
        .src_ready (src_ready),
        .k_ivalid  (k_ivalid),
        .k_iready  (k_iready),
        .k_ovalid  (k_ovalid),
        .k_oready  (k_oready),
        .snk_valid (snk_valid),
        .snk_ready (snk_ready),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .in_cnt    (in_cnt),
        .out_cnt   (out_cnt)
    );

    always #5 clk = ~clk;

    assign k_ovalid = kov_model | stray_ov;

    // Kernel model: FIFO of beat ids, each releasable two cycles after entry
    always @(negedge clk) begin
        kov_model <= kern_en && (kt.size() > 0) && (kt[0] <= cyc);
    end

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        done_cnt <= done_cnt + (done ? 1 : 0);
        sr_hi    <= sr_hi + (src_ready ? 1 : 0);
        if (!rst) begin
            kq.delete();
            kt.delete();
            exp_id <= src_id;
        end else begin
            if (k_ovalid && k_oready) begin
                out_beats <= out_beats + 1;
                exp_id    <= exp_id + 1;
                if (kq.size() > 0) begin
                    if (kq.pop_front() != exp_id) seq_err <= seq_err + 1;
                    void'(kt.pop_front());
                end else begin
                    seq_err <= seq_err + 1;
                end
            end
            if (k_ivalid && k_iready) begin
                kq.push_back(src_id);
                kt.push_back(cyc + 2);
                src_id   <= src_id + 1;
                in_beats <= in_beats + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_in   = in_beats;
        b_out  = out_beats;
        b_done = done_cnt;
        b_sr   = sr_hi;
        b_seq  = seq_err;
    endtask

    task automatic pulse_start(input logic [15:0] n);
        @(negedge clk);
        start     = 1'b1;
        num_items = n;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int viol;
        int n;
        rst       = 1'b0;
        start     = 1'b0;
        num_items = 16'd0;
        src_valid = 1'b1;
        k_iready  = 1'b1;
        snk_ready = 1'b1;
        stray_ov  = 1'b1;
        kern_en   = 1'b0;

        // Reset: all flags, counters and handshakes low
        repeat (3) @(negedge clk);
        check("rst_flags", 32'({busy, done, err, src_ready, k_ivalid, k_oready, snk_valid}), 32'd0);
        check("rst_cnts", 32'({in_cnt, out_cnt}), 32'd0);
        rst      = 1'b1;
        stray_ov = 1'b0;
        kern_en  = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_gate", 32'({busy, src_ready, k_ivalid}), 32'd0);

        // Basic job, N=8
        snap();
        pulse_start(16'd8);
        check("basic_busy_run", 32'(busy), 32'd1);
        wait_done(200, "basic_done_seen");
        check("basic_busy_at_done", 32'(busy), 32'd0);
        check("basic_in_cnt", 32'(in_cnt), 32'd8);
        check("basic_out_cnt", 32'(out_cnt), 32'd8);
        @(negedge clk);
        check("basic_done_one_cycle", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        check("basic_cnt_hold", 32'({in_cnt, out_cnt}), {16'd8, 16'd8});
        check("basic_beats_in", 32'(in_beats - b_in), 32'd8);
        check("basic_beats_out", 32'(out_beats - b_out), 32'd8);
        check("basic_done_pulses", 32'(done_cnt - b_done), 32'd1);
        check("basic_seq_err", 32'(seq_err - b_seq), 32'd0);

        // Zero length job, with start held through DONE
        snap();
        @(negedge clk);
        start     = 1'b1;
        num_items = 16'd0;
        @(negedge clk);
        check("zero_done", 32'({done, busy}), 32'b10);
        @(negedge clk);
        check("zero_back_idle", 32'({done, busy}), 32'b00);
        start = 1'b0;
        @(negedge clk);
        check("zero_start_in_done_ignored", 32'({done, busy}), 32'b00);
        check("zero_src_ready_never", 32'(sr_hi - b_sr), 32'd0);
        check("zero_cnts", 32'({in_cnt, out_cnt}), 32'd0);

        // Back-pressure: snk_ready toggling, k_iready low for three cycles
        snap();
        viol = 0;
        pulse_start(16'd4);
        for (int i = 0; i < 200 && done !== 1'b1; i++) begin
            if ((in_beats - b_in) >= 4 && src_ready) viol++;
            snk_ready = i[0];
            k_iready  = !(i >= 1 && i <= 3);
            @(negedge clk);
        end
        check("bp_done_seen", 32'(done), 32'd1);
        snk_ready = 1'b1;
        k_iready  = 1'b1;
        check("bp_out_cnt", 32'(out_cnt), 32'd4);
        check("bp_beats", 32'({16'(in_beats - b_in), 16'(out_beats - b_out)}), {16'd4, 16'd4});
        check("bp_seq_err", 32'(seq_err - b_seq), 32'd0);
        check("bp_src_ready_after_last", 32'(viol), 32'd0);

        // Overrun guard: src_valid held high, then a stray kernel output in IDLE
        snap();
        viol = 0;
        pulse_start(16'd3);
        for (int i = 0; i < 200 && done !== 1'b1; i++) begin
            if ((in_beats - b_in) >= 3 && k_ivalid) viol++;
            @(negedge clk);
        end
        check("ovr_done_seen", 32'(done), 32'd1);
        check("ovr_ivalid_after_last", 32'(viol), 32'd0);
        check("ovr_beats_in", 32'(in_beats - b_in), 32'd3);
        repeat (2) @(negedge clk);
        stray_ov = 1'b1;
        #1;
        check("ovr_stray_blocked", 32'({k_oready, snk_valid}), 32'd0);
        @(negedge clk);
        stray_ov = 1'b0;
        check("ovr_stray_no_beat", 32'(out_beats - b_out), 32'd3);

        // Reset mid-job at in_cnt=2 of N=5, then a normal N=2 job
        snap();
        kern_en = 1'b0;
        pulse_start(16'd5);
        n = 0;
        while (in_cnt != 16'd2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_reach_two", 32'(in_cnt), 32'd2);
        rst = 1'b0;
        @(negedge clk);
        check("mid_rst_state", 32'({busy, done, src_ready, k_ivalid}), 32'd0);
        check("mid_rst_cnts", 32'({in_cnt, out_cnt}), 32'd0);
        rst     = 1'b1;
        kern_en = 1'b1;
        repeat (2) @(negedge clk);
        check("mid_no_done", 32'(done_cnt - b_done), 32'd0);
        snap();
        pulse_start(16'd2);
        wait_done(100, "mid_restart_done");
        check("mid_restart_cnts", 32'({in_cnt, out_cnt}), {16'd2, 16'd2});
        check("mid_restart_seq", 32'(seq_err - b_seq), 32'd0);
        @(negedge clk);

`ifdef KERNEL_A_SEQ_TIMEOUT_EN
        // Watchdog: kernel never answers, ERR after TIMEOUT idle cycles
        snap();
        kern_en = 1'b0;
        pulse_start(16'd4);
        n = 0;
        while (in_cnt != 16'd4 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("to_inputs_in", 32'(in_cnt), 32'd4);
        repeat (15) @(negedge clk);
        check("to_not_yet", 32'({err, busy}), 32'b01);
        @(negedge clk);
        check("to_err_set", 32'({err, busy}), 32'b10);
        repeat (6) @(negedge clk);
        check("to_err_sticky", 32'(err), 32'd1);
        check("to_no_done", 32'(done_cnt - b_done), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("to_err_cleared", 32'({err, busy}), 32'd0);
        kern_en = 1'b1;
`else
        // No watchdog: DRAIN waits indefinitely and ignores start
        snap();
        kern_en = 1'b0;
        pulse_start(16'd2);
        repeat (60) @(negedge clk);
        check("wait_busy", 32'({busy, err}), 32'b10);
        check("wait_cnts", 32'({in_cnt, out_cnt}), {16'd2, 16'd0});
        pulse_start(16'd7);
        check("wait_start_ignored", 32'(in_cnt), 32'd2);
        kern_en = 1'b1;
        wait_done(100, "wait_done_seen");
        check("wait_final_cnts", 32'({in_cnt, out_cnt}), {16'd2, 16'd2});
        check("wait_no_err", 32'(err), 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
